mem_port_arbiter: RTL and testbench

Shares the processor's single 16-bit memory port between two requesters: the CPU datapath (fetch/load/store) and an external DMA/loader port.
- CPU has fixed priority.
- A starvation counter guarantees the DMA requester forward progress.
- Read data returns one cycle after grant and is routed back to the requester that owned the access.
- Sits between the processor datapath and memory; the control unit uses cpu_stall to hold PCWrite/InstWrite.

---
 rtl/frankie_mem_pkg.sv | 14 +
 rtl/mem_port_arbiter_starve_counter.sv | 26 ++
 rtl/mem_port_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/frankie_mem_pkg.sv
// Shared definitions for the Frankie memory port: read-owner encoding and default widths.
package frankie_mem_pkg;

    localparam int DEF_AW           = 16;
    localparam int DEF_DW           = 16;
    localparam int DEF_STARVE_LIMIT = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } rd_owner_e;

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating 4-bit counter of contested cycles the CPU has won; flags when DMA must be forced.
module starve_counter #(
    parameter int LIMIT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic at_limit
);

    localparam logic [3:0] LIMIT_V = 4'(LIMIT);

    logic [3:0] count;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= 4'd0;
        end else if (inc && (count != LIMIT_V)) begin
            count <= count + 4'd1;
        end
    end

    assign at_limit = (count == LIMIT_V);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester memory port arbiter: fixed CPU priority with a DMA starvation override.
// Optional contention/forced-grant counters are built when MEM_ARB_PERF_CNT_EN is defined.
module mem_port_arbiter
    import frankie_mem_pkg::*;
#(
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
    parameter int AW           = DEF_AW,
    parameter int DW           = DEF_DW
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_kernel,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_stall,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_gnt,
    output logic          dma_rvalid,
    output logic [DW-1:0] dma_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    output logic [15:0]   perf_contend,
    output logic [15:0]   perf_forced
`endif
);

    logic      contested;
    logic      force_dma;
    logic      starve_at_limit;
    rd_owner_e rd_owner;
    rd_owner_e rd_owner_nxt;
    logic [DW-1:0] cpu_rdata_q;
    logic [DW-1:0] dma_rdata_q;

    assign contested = cpu_req & dma_req;
    assign force_dma = contested & ~in_kernel & starve_at_limit;
    assign dma_gnt   = ~reset & dma_req & (~cpu_req | force_dma);
    assign cpu_gnt   = ~reset & cpu_req & ~force_dma;
    assign cpu_stall = cpu_req & ~cpu_gnt;

    starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clock    (clock),
        .reset    (reset),
        .clear    (dma_gnt | ~dma_req | in_kernel),
        .inc      (contested & cpu_gnt),
        .at_limit (starve_at_limit)
    );

    // CPU values sit on the bus when idle; mem_we only ever follows a grant.
    always_comb begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = cpu_we & cpu_gnt;
        if (dma_gnt) begin
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
            mem_we    = dma_we;
        end
    end

    always_comb begin
        rd_owner_nxt = OWN_NONE;
        if (cpu_gnt && !cpu_we) begin
            rd_owner_nxt = OWN_CPU;
        end else if (dma_gnt && !dma_we) begin
            rd_owner_nxt = OWN_DMA;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_owner <= OWN_NONE;
        end else begin
            rd_owner <= rd_owner_nxt;
        end
    end

    // Gating with reset drops a read return that lands in a reset cycle.
    assign cpu_rvalid = ~reset & (rd_owner == OWN_CPU);
    assign dma_rvalid = ~reset & (rd_owner == OWN_DMA);
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_q;
    assign dma_rdata  = dma_rvalid ? mem_rdata : dma_rdata_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            if (cpu_rvalid) cpu_rdata_q <= mem_rdata;
            if (dma_rvalid) dma_rdata_q <= mem_rdata;
        end
    end

`ifdef MEM_ARB_PERF_CNT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_contend <= 16'd0;
            perf_forced  <= 16'd0;
        end else begin
            if (contested) perf_contend <= perf_contend + 16'd1;
            if (force_dma && dma_gnt) perf_forced <= perf_forced + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; a second instance runs with STARVE_LIMIT = 1.
module tb_mem_port_arbiter;

    logic        clock;
    logic        reset;
    logic        in_kernel;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [15:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata, mem_rdata;

    logic        cpu_gnt, cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid, mem_we;
    logic [15:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;

    logic        cpu_gnt1, cpu_stall1, cpu_rvalid1, dma_gnt1, dma_rvalid1, mem_we1;
    logic [15:0] cpu_rdata1, dma_rdata1, mem_addr1, mem_wdata1;

`ifdef MEM_ARB_PERF_CNT_EN
    logic [15:0] perf_contend, perf_forced, perf_contend1, perf_forced1;
`endif

    int errors = 0;
    int checks = 0;

    mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clock(clock), .reset(reset), .in_kernel(in_kernel),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
`ifdef MEM_ARB_PERF_CNT_EN
        , .perf_contend(perf_contend), .perf_forced(perf_forced)
`endif
    );

    mem_port_arbiter #(.STARVE_LIMIT(1)) dut1 (
        .clock(clock), .reset(reset), .in_kernel(in_kernel),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt1), .cpu_stall(cpu_stall1), .cpu_rvalid(cpu_rvalid1), .cpu_rdata(cpu_rdata1),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt1), .dma_rvalid(dma_rvalid1), .dma_rdata(dma_rdata1),
        .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_we(mem_we1), .mem_rdata(mem_rdata)
`ifdef MEM_ARB_PERF_CNT_EN
        , .perf_contend(perf_contend1), .perf_forced(perf_forced1)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Inputs change just after the rising edge; returns mid-cycle so outputs can be sampled.
    task automatic applyStimulus(input logic rst, input logic kern,
                                 input logic c_req, input logic c_we, input logic [15:0] c_addr, input logic [15:0] c_wdata,
                                 input logic d_req, input logic d_we, input logic [15:0] d_addr, input logic [15:0] d_wdata);
        @(posedge clock);
        #1;
        reset     = rst;
        in_kernel = kern;
        cpu_req   = c_req;
        cpu_we    = c_we;
        cpu_addr  = c_addr;
        cpu_wdata = c_wdata;
        dma_req   = d_req;
        dma_we    = d_we;
        dma_addr  = d_addr;
        dma_wdata = d_wdata;
        #3;
    endtask

    task automatic idleCycle(input logic rst);
        applyStimulus(rst, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    task automatic contendCycle(input logic kern, input logic exp_dma, input int idx, input string tag);
        logic [15:0] ca;
        logic [15:0] da;
        ca = 16'h1000 + 16'(idx);
        da = 16'h2000 + 16'(idx);
        applyStimulus(1'b0, kern, 1'b1, 1'b0, ca, 16'h0000, 1'b1, 1'b0, da, 16'h0000);
        checkOutput({tag, "_cpu_gnt"}, 32'(cpu_gnt), 32'(!exp_dma));
        checkOutput({tag, "_dma_gnt"}, 32'(dma_gnt), 32'(exp_dma));
        checkOutput({tag, "_stall"}, 32'(cpu_stall), 32'(exp_dma));
        checkOutput({tag, "_addr"}, 32'(mem_addr), 32'(exp_dma ? da : ca));
    endtask

    initial begin
        reset = 1'b1; in_kernel = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
        mem_rdata = '0;

        // Reset state; grants held off while reset is high
        idleCycle(1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 1'b0, 16'h0020, 16'h0000);
        checkOutput("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
        checkOutput("rst_dma_gnt", 32'(dma_gnt), 32'd0);
        checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
        checkOutput("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        checkOutput("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
        checkOutput("rst_dma_rdata", 32'(dma_rdata), 32'd0);

        // CPU read alone
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        checkOutput("rd_cpu_gnt", 32'(cpu_gnt), 32'd1);
        checkOutput("rd_mem_addr", 32'(mem_addr), 32'h0010);
        checkOutput("rd_mem_we", 32'(mem_we), 32'd0);
        checkOutput("rd_dma_gnt", 32'(dma_gnt), 32'd0);
        idleCycle(1'b0);
        mem_rdata = 16'hBEEF;
        #1;
        checkOutput("rd_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
        checkOutput("rd_cpu_rdata", 32'(cpu_rdata), 32'hBEEF);
        checkOutput("rd_dma_rvalid", 32'(dma_rvalid), 32'd0);
        checkOutput("rd_dma_rdata", 32'(dma_rdata), 32'h0000);
        idleCycle(1'b0);
        mem_rdata = 16'h5555;
        #1;
        checkOutput("rd_hold_rvalid", 32'(cpu_rvalid), 32'd0);
        checkOutput("rd_hold_rdata", 32'(cpu_rdata), 32'hBEEF);

        // DMA write with CPU idle, then DMA read
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0200, 16'h1234);
        checkOutput("dw_dma_gnt", 32'(dma_gnt), 32'd1);
        checkOutput("dw_mem_we", 32'(mem_we), 32'd1);
        checkOutput("dw_mem_addr", 32'(mem_addr), 32'h0200);
        checkOutput("dw_mem_wdata", 32'(mem_wdata), 32'h1234);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0300, 16'h0000);
        checkOutput("dw_no_rvalid", 32'(dma_rvalid), 32'd0);
        checkOutput("dr_mem_we", 32'(mem_we), 32'd0);
        idleCycle(1'b0);
        mem_rdata = 16'hA5A5;
        #1;
        checkOutput("dr_dma_rvalid", 32'(dma_rvalid), 32'd1);
        checkOutput("dr_dma_rdata", 32'(dma_rdata), 32'hA5A5);
        checkOutput("dr_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        checkOutput("dr_cpu_rdata", 32'(cpu_rdata), 32'hBEEF);

        // Fresh reset so perf counters start from zero
        idleCycle(1'b1);

        // Continuous contention: 4 CPU wins then one DMA; limit-1 instance alternates
        for (int i = 0; i < 10; i++) begin
            contendCycle(1'b0, (i % 5) == 4, i, $sformatf("cont%0d", i));
            checkOutput($sformatf("alt%0d_dma_gnt", i), 32'(dma_gnt1), 32'((i % 2) == 1));
            checkOutput($sformatf("alt%0d_cpu_gnt", i), 32'(cpu_gnt1), 32'((i % 2) == 0));
            mem_rdata = 16'h7000 + 16'(i);
            #1;
            if (i > 0) begin
                checkOutput($sformatf("cont%0d_cpu_rvalid", i), 32'(cpu_rvalid), 32'(((i - 1) % 5) != 4));
                checkOutput($sformatf("cont%0d_dma_rvalid", i), 32'(dma_rvalid), 32'(((i - 1) % 5) == 4));
            end
        end
        idleCycle(1'b0);
`ifdef MEM_ARB_PERF_CNT_EN
        checkOutput("perf_contend", 32'(perf_contend), 32'd10);
        checkOutput("perf_forced", 32'(perf_forced), 32'd2);
`endif

        // Kernel mode: CPU always wins, never stalls
        for (int i = 0; i < 7; i++) begin
            contendCycle(1'b1, 1'b0, i, $sformatf("kern%0d", i));
        end

        // Kernel rising at the limit gates force_dma and clears the count
        for (int i = 0; i < 4; i++) contendCycle(1'b0, 1'b0, i, $sformatf("pre%0d", i));
        contendCycle(1'b1, 1'b0, 4, "kern_at_limit");
        for (int i = 0; i < 4; i++) contendCycle(1'b0, 1'b0, i, $sformatf("post%0d", i));
        contendCycle(1'b0, 1'b1, 4, "post_force");

        // DMA dropping its request clears a pending count
        for (int i = 0; i < 3; i++) contendCycle(1'b0, 1'b0, i, $sformatf("drop%0d", i));
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0044, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        checkOutput("drop_cpu_gnt", 32'(cpu_gnt), 32'd1);
        for (int i = 0; i < 4; i++) contendCycle(1'b0, 1'b0, i, $sformatf("redo%0d", i));
        contendCycle(1'b0, 1'b1, 4, "redo_force");

        // Reset the cycle after a CPU read grant
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0050, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        checkOutput("rr_cpu_gnt", 32'(cpu_gnt), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 16'h0050, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        mem_rdata = 16'hCAFE;
        #1;
        checkOutput("rr_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        checkOutput("rr_cpu_gnt_in_reset", 32'(cpu_gnt), 32'd0);
        idleCycle(1'b0);
        checkOutput("rr_after_rvalid", 32'(cpu_rvalid), 32'd0);
        checkOutput("rr_after_cpu_rdata", 32'(cpu_rdata), 32'd0);
        checkOutput("rr_after_dma_rdata", 32'(dma_rdata), 32'd0);
        checkOutput("rr_after_mem_we", 32'(mem_we), 32'd0);
`ifdef MEM_ARB_PERF_CNT_EN
        checkOutput("rr_perf_contend", 32'(perf_contend), 32'd0);
        checkOutput("rr_perf_forced", 32'(perf_forced), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
